// File: rtl/bcd2bin.sv
// Sequential signed 3-digit BCD to two's-complement converter (reverse double-dabble).
// Optional build macro SATURATE_EN: clamp bin to the representable range on overflow.
module bcd2bin #(
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             bcd_h,
  input  logic [3:0]             bcd_t,
  input  logic [3:0]             bcd_u,
  input  logic                   sign_in,
  input  logic                   start,
  output logic [WORD_LENGTH-1:0] bin,
  output logic                   ready,
  output logic                   busy,
  output logic                   overflow,
  output logic                   bcd_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [16:0] POS_MAX = 17'((17'd1 << (WORD_LENGTH - 1)) - 17'd1);
  localparam logic [16:0] NEG_MAX = 17'(POS_MAX + 17'd1);

  state_t                 r_state;
  logic [11:0]            r_d;
  logic [11:0]            r_b;
  logic [3:0]             r_cnt;
  logic                   r_sign;
  logic                   r_err;

  logic [23:0]            w_shift;
  logic [11:0]            w_d_fix;
  logic [16:0]            w_mag;
  logic [WORD_LENGTH-1:0] w_mag_w;
  logic                   w_ovf;
  logic [WORD_LENGTH-1:0] w_bin;

  function automatic logic [3:0] fix_digit(input logic [3:0] dig);
    if (dig >= 4'd8) begin
      return dig - 4'd3;
    end else begin
      return dig;
    end
  endfunction

  assign w_shift = {1'b0, r_d, r_b[11:1]};
  assign w_d_fix = {fix_digit(w_shift[23:20]), fix_digit(w_shift[19:16]), fix_digit(w_shift[15:12])};
  assign w_mag   = 17'(r_b[9:0]);
  assign w_mag_w = WORD_LENGTH'(r_b[9:0]);

  // Result word and overflow flag from the finished magnitude and captured sign.
  always_comb begin
    w_ovf = 1'b0;
    w_bin = '0;
    if (r_sign) begin
      w_ovf = (w_mag > POS_MAX);
      w_bin = w_mag_w;
    end else begin
      w_ovf = (w_mag > NEG_MAX);
      w_bin = ~w_mag_w + WORD_LENGTH'(1);
    end
`ifdef SATURATE_EN
    if (w_ovf) begin
      if (r_sign) begin
        w_bin = {1'b0, {(WORD_LENGTH-1){1'b1}}};
      end else begin
        w_bin = {1'b1, {(WORD_LENGTH-1){1'b0}}};
      end
    end else begin
      w_bin = w_bin;
    end
`endif
    if (r_err) begin
      w_ovf = 1'b0;
      w_bin = '0;
    end else begin
      w_ovf = w_ovf;
    end
  end

  // Control FSM, shift datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_d      <= 12'd0;
      r_b      <= 12'd0;
      r_cnt    <= 4'd0;
      r_sign   <= 1'b0;
      r_err    <= 1'b0;
      bin      <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      bcd_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready <= 1'b0;
          if (start) begin
            r_d     <= {bcd_h, bcd_t, bcd_u};
            r_sign  <= sign_in;
            r_err   <= (bcd_h > 4'd9) | (bcd_t > 4'd9) | (bcd_u > 4'd9);
            r_b     <= 12'd0;
            r_cnt   <= 4'd0;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end else begin
            busy    <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_d   <= w_d_fix;
          r_b   <= w_shift[11:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd11) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_DONE: begin
          // busy stays high through the ready cycle and drops in IDLE.
          bin      <= w_bin;
          overflow <= w_ovf;
          bcd_err  <= r_err;
          ready    <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
